mac_scheduler: RTL

Round-robin scheduler and sequencer for the shared multiply-accumulate datapath of the neuron unit. Up to NREQ requesters each post a dot-product job of a given length. The block grants the datapath to one requester at a time. It then steps the datapath through accumulator clear, per-term load/multiply/accumulate, and write-back, and pulses a per-requester done. It replaces the single-user start/done controller once several neurons share one MAC.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mac_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the MAC scheduler: state encoding, default sizes and
// per-term cycle count.
package mac_pkg;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefLenW    = 4;
  localparam int unsigned TermCycles = 4;

  localparam int unsigned StateW = 4;

  localparam logic [StateW-1:0] StIdle  = 4'd0;
  localparam logic [StateW-1:0] StArb   = 4'd1;
  localparam logic [StateW-1:0] StInit  = 4'd2;
  localparam logic [StateW-1:0] StLoad  = 4'd3;
  localparam logic [StateW-1:0] StMult  = 4'd4;
  localparam logic [StateW-1:0] StAcc   = 4'd5;
  localparam logic [StateW-1:0] StCheck = 4'd6;
  localparam logic [StateW-1:0] StWb    = 4'd7;
  localparam logic [StateW-1:0] StDone  = 4'd8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after the last
// winner and commits the new winner when upd is asserted.
module rr_arbiter import mac_pkg::*; #(
  parameter int unsigned NREQ = DefNreq
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] win,
  output logic            any
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    win     = '0;
    win_idx = last_q;
    cand    = last_q;
    found   = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        win[cand]  = 1'b1;
        win_idx    = cand;
      end
    end
    any = found;
  end

  // Reset to the top requester so requester 0 wins the first pick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= IdxW'(NREQ - 1);
    end else if (upd && found) begin
      last_q <= win_idx;
    end
  end

endmodule

// File: rtl/mac_scheduler.sv
// Grants the shared MAC datapath round-robin and sequences clear, per-term
// load/multiply/accumulate and write-back for the granted job.
module mac_scheduler import mac_pkg::*; #(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [LEN_W-1:0]      idx,
  output logic                  dp_clr_acc,
  output logic                  dp_load,
  output logic                  dp_mult_en,
  output logic                  dp_acc_en,
  output logic                  dp_wb,
  output logic [NREQ-1:0]       done
);

  logic [StateW-1:0] state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   win;
  logic              win_any;
  logic              arb_upd;
  logic [LEN_W-1:0]  len_sel;

  assign arb_upd = (state_q == StArb);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .upd (arb_upd),
    .win (win),
    .any (win_any)
  );

  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) len_sel = len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    case (state_q)
      StIdle: if (|req) state_d = StArb;
      StArb: begin
        // A request withdrawn before arbitration leaves nothing to run.
        if (win_any) begin
          gnt_d   = win;
          len_d   = len_sel;
          state_d = StInit;
        end else begin
          state_d = StIdle;
        end
      end
      StInit: begin
        idx_d   = '0;
        state_d = (len_q == '0) ? StWb : StLoad;
      end
      StLoad: state_d = StMult;
      StMult: state_d = StAcc;
      StAcc:  state_d = StCheck;
      StCheck: begin
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = StWb;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = StLoad;
        end
      end
      StWb:   state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    idx        = idx_q;
    dp_clr_acc = (state_q == StInit);
    dp_load    = (state_q == StLoad);
    dp_mult_en = (state_q == StMult);
    dp_acc_en  = (state_q == StAcc);
    dp_wb      = (state_q == StWb);
    done       = (state_q == StDone) ? gnt_q : '0;
    gnt        = '0;
    case (state_q)
      StInit, StLoad, StMult, StAcc, StCheck, StWb, StDone: gnt = gnt_q;
      default: gnt = '0;
    endcase
  end

endmodule
